// File: rtl/sram_port_pkg.sv
// Shared types for the SRAM port master: controller states and request/response type encodings.
package sram_port_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/sram_resp_queue.sv
// Bypass FIFO for SRAM responses: an incoming message is presented immediately when empty
// and only stored if the consumer does not take it in the same cycle.
module sram_resp_queue #(
    parameter int depth = 2,
    parameter int width = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_val,
    input  logic [width-1:0]             enq_msg,
    output logic                         deq_val,
    input  logic                         deq_rdy,
    output logic [width-1:0]             deq_msg,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_count == '0);
    assign deq_val = !w_empty || enq_val;
    assign deq_msg = w_empty ? enq_msg : r_mem[r_head];
    assign w_pop   = !w_empty && deq_rdy;
    assign w_push  = enq_val && !(w_empty && deq_rdy);
    assign count   = r_count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(depth - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // NOTE: storage has no reset; head/tail/count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= enq_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= next_ptr(r_tail);
            if (w_pop)  r_head <= next_ptr(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_master.sv
// Val/rdy initiator for a single-port SRAM macro with zero-fill after reset.
// Define SRAM_PORT_MASTER_WRITE_ACK_EN to return a response for every write as well as every read.
module sram_port_master
    import sram_port_pkg::*;
#(
    parameter int num_bits   = 128,
    parameter int num_words  = 256,
    parameter int resp_depth = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_val,
    output logic                          req_rdy,
    input  logic                          req_type,
    input  logic [$clog2(num_words)-1:0]  req_addr,
    input  logic [num_bits-1:0]           req_data,
    input  logic [num_bits/8-1:0]         req_wbm,
    output logic                          resp_val,
    input  logic                          resp_rdy,
    output logic                          resp_type,
    output logic [num_bits-1:0]           resp_data,
    output logic [$clog2(num_words)-1:0]  A1,
    output logic                          CSB1,
    output logic                          WEB1,
    output logic [num_bits/8-1:0]         WBM1,
    output logic [num_bits-1:0]           I1,
    output logic                          OEB1,
    output logic                          CE1,
    input  logic [num_bits-1:0]           O1
);

    localparam int AW = $clog2(num_words);
    localparam int CW = $clog2(resp_depth + 1);
    localparam int MW = num_bits + 1;

`ifdef SRAM_PORT_MASTER_WRITE_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    state_t          r_state;
    logic [AW-1:0]   r_init_cnt;
    logic            r_inflight;
    logic            r_inflight_type;

    logic            w_fire;
    logic            w_resp_fire;
    logic [CW:0]     w_used;
    logic [CW-1:0]   w_count;
    logic            w_deq_val;
    logic [MW-1:0]   w_enq_msg;
    logic [MW-1:0]   w_deq_msg;

    // A request is only accepted if its response is guaranteed a buffer slot.
    assign w_used      = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign req_rdy     = reset && (r_state == READY) && (w_used < (CW+1)'(resp_depth));
    assign w_fire      = req_val && req_rdy;
    assign w_resp_fire = w_fire && ((req_type == MEM_READ) || ACK_EN);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        CE1  = 1'b1;
        CSB1 = 1'b1;
        WEB1 = 1'b1;
        A1   = '0;
        I1   = '0;
        WBM1 = '0;
        if (reset) begin
            if (r_state == INIT) begin
                CSB1 = 1'b0;
                WEB1 = 1'b0;
                WBM1 = '1;
                A1   = r_init_cnt;
            end else begin
                CSB1 = !w_fire;
                WEB1 = !req_type;
                if (w_fire) begin
                    A1   = req_addr;
                    I1   = req_data;
                    WBM1 = req_wbm;
                end
            end
        end
    end

    assign OEB1 = !(reset && r_inflight && (r_inflight_type == MEM_READ));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= INIT;
            r_init_cnt      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_type <= MEM_READ;
        end else begin
            r_inflight      <= w_resp_fire;
            r_inflight_type <= req_type;
            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + AW'(1);
                    if (r_init_cnt == AW'(num_words - 1)) r_state <= READY;
                end
                READY:   r_state <= READY;
                default: r_state <= INIT;
            endcase
        end
    end

    // Write acks carry zero data; read data is taken straight off O1 the cycle after issue.
    assign w_enq_msg = {r_inflight_type, (r_inflight_type == MEM_READ) ? O1 : {num_bits{1'b0}}};

    sram_resp_queue #(
        .depth (resp_depth),
        .width (MW)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (reset && r_inflight),
        .enq_msg (w_enq_msg),
        .deq_val (w_deq_val),
        .deq_rdy (resp_rdy),
        .deq_msg (w_deq_msg),
        .count   (w_count)
    );

    assign resp_val  = reset && w_deq_val;
    assign resp_type = ACK_EN ? w_deq_msg[num_bits] : MEM_READ;
    assign resp_data = w_deq_msg[num_bits-1:0];

endmodule
